// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared FSM state type, Gray pattern sequence and truth-table constants for the gate BIST sequencer
package gate_bist_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    // {sw0,sw1} per step; Gray order so only one CUT input toggles per step
    localparam logic [1:0] PAT_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Expected L indexed by {sw0,sw1}; bit3 is pattern 11
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;

endpackage

// File: rtl/gate_bist_if.sv
// gate_bist_if: sequencer <-> board/CUT signal bundle
//   start            run request from board logic
//   sw0, sw1         CUT inputs driven by the sequencer
//   l                CUT output
//   busy, done, pass run status
//   err_cnt          mismatch count (0..4)
//   fail_idx         {sw0,sw1} of first mismatching pattern
// slave = sequencer side, master = board/CUT side
interface gate_bist_if;
    logic       start;
    logic       sw0;
    logic       sw1;
    logic       l;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [1:0] fail_idx;

    modport master (output start, l, input sw0, sw1, busy, done, pass, err_cnt, fail_idx);
    modport slave  (input start, l, output sw0, sw1, busy, done, pass, err_cnt, fail_idx);
endinterface

// File: rtl/gate_bist_start_sync.sv
// gate_bist_start_sync: 2-flop synchroniser plus rising-edge detector for the START request
//   clk, rst  clock and asynchronous active-high reset
//   din       raw asynchronous START
//   rise      one-cycle pulse per synchronised 0->1 transition
module gate_bist_start_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic [2:0] s;

    always_ff @(posedge clk or posedge rst)
        if (rst) s <= '0;
        else     s <= {s[1:0], din};

    // s[1] is the synchronised level, s[2] its previous value
    assign rise = s[1] & ~s[2];
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer that walks a 2-input gate CUT through all four patterns and checks L against TRUTH
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  gate_bist_if.slave: start in, l in, sw0/sw1/busy/done/pass/err_cnt/fail_idx out
// Parameters: DWELL (cycles held before sampling, >=1), TRUTH (expected L by {sw0,sw1})
// Option: define GATE_BIST_START_SYNC_EN to synchronise START and launch only on its rising edge
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int         DWELL = 4,
    parameter logic [3:0] TRUTH = TRUTH_AND
) (
    input logic        clk,
    input logic        rst,
    gate_bist_if.slave bus
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;

    if (DWELL < 1) begin : g_dwell_chk
        $error("gate_bist_ctrl: DWELL must be >= 1");
    end

    logic go;
`ifdef GATE_BIST_START_SYNC_EN
    gate_bist_start_sync u_sync (.clk(clk), .rst(rst), .din(bus.start), .rise(go));
`else
    assign go = bus.start;
`endif

    state_t        state, state_n;
    logic [1:0]    step, step_n;
    logic [1:0]    sw, sw_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    err, err_n;
    logic [1:0]    fidx, fidx_n;
    logic          pass, pass_n;
    logic          miss;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            sw    <= '0;
            cnt   <= '0;
            err   <= '0;
            fidx  <= '0;
            pass  <= 1'b0;
        end else begin
            state <= state_n;
            step  <= step_n;
            sw    <= sw_n;
            cnt   <= cnt_n;
            err   <= err_n;
            fidx  <= fidx_n;
            pass  <= pass_n;
        end

    always_comb begin
        state_n = state;
        step_n  = step;
        sw_n    = sw;
        cnt_n   = cnt;
        err_n   = err;
        fidx_n  = fidx;
        pass_n  = pass;
        miss    = bus.l != TRUTH[sw];
        case (state)
            IDLE:
                if (go) begin
                    state_n = DRIVE;
                    step_n  = '0;
                    sw_n    = PAT_SEQ[0];
                    cnt_n   = '0;
                    err_n   = '0;
                    fidx_n  = '0;
                    pass_n  = 1'b0;
                end
            DRIVE: begin
                cnt_n   = cnt + 1'b1;
                state_n = cnt == CW'(DWELL - 1) ? SAMPLE : DRIVE;
            end
            SAMPLE: begin
                // err never exceeds 4 because only four samples are taken per run
                err_n  = miss ? err + 3'd1 : err;
                fidx_n = miss && err == 3'd0 ? sw : fidx;
                if (step == 2'd3) begin
                    state_n = FINISH;
                    sw_n    = '0;
                    pass_n  = err_n == 3'd0;
                end else begin
                    state_n = DRIVE;
                    step_n  = step + 2'd1;
                    sw_n    = PAT_SEQ[step + 2'd1];
                    cnt_n   = '0;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.sw0      = sw[1];
    assign bus.sw1      = sw[0];
    assign bus.busy     = state == DRIVE || state == SAMPLE;
    assign bus.done     = state == FINISH;
    assign bus.pass     = pass;
    assign bus.err_cnt  = err;
    assign bus.fail_idx = fidx;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: self-checking bench for gate_bist_ctrl with a behavioural CUT and reference model
module tb_gate_bist_ctrl;
    localparam int         DWELL = 4;
    localparam logic [3:0] TRUTH = 4'b1000;
`ifdef GATE_BIST_START_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] cut;
    int         total;
    int         passed;
    int         fails;

    gate_bist_if bus();

    gate_bist_ctrl #(.DWELL(DWELL), .TRUTH(TRUTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // behavioural CUT: arbitrary 2-input function given as a truth table
    assign bus.l = cut[{bus.sw0, bus.sw1}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

`define CHK(obs, exp, tag) \
    begin \
        total++; \
        assert ((obs) === (exp)) passed++; \
        else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
        end \
    end

    function automatic logic [1:0] gray(input int k);
        return 2'(k ^ (k >> 1));
    endfunction

    // expected result: walk the four Gray-order patterns and compare CUT vs TRUTH
    function automatic void model(input logic [3:0] tt, output logic [2:0] e, output logic [1:0] f);
        logic [1:0] p;
        e = 0;
        f = 0;
        for (int k = 0; k < 4; k++) begin
            p = gray(k);
            if (tt[p] !== TRUTH[p]) begin
                if (e == 0) f = p;
                e++;
            end
        end
    endfunction

    // one-cycle START pulse; returns number of edges until busy is seen
    task automatic launch(output int lat);
        lat = 0;
        @(negedge clk);
        bus.start = 1'b1;
        while (bus.busy !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
    endtask

    task automatic run_check(input logic [3:0] tt, input bit poke, input string tag);
        int lat, nb, bad, extra;
        logic [2:0] e_err;
        logic [1:0] e_idx;
        model(tt, e_err, e_idx);
        cut = tt;
        launch(lat);
        `CHK(lat, LAT, {tag, " latency"})
        nb = 0;
        bad = 0;
        while (bus.busy === 1'b1 && nb < 200) begin
            if ({bus.sw0, bus.sw1} !== gray(nb / (DWELL + 1))) bad++;
            if (poke && nb == 7) bus.start = 1'b1;
            if (poke && nb == 8) bus.start = 1'b0;
            nb++;
            @(negedge clk);
        end
        `CHK(nb, 4 * (DWELL + 1), {tag, " busy_len"})
        `CHK(bad, 0, {tag, " pattern_seq"})
        `CHK(bus.done, 1'b1, {tag, " done"})
        `CHK({bus.sw0, bus.sw1}, 2'b00, {tag, " sw_finish"})
        `CHK(bus.pass, e_err == 3'd0, {tag, " pass"})
        `CHK(bus.err_cnt, e_err, {tag, " err_cnt"})
        `CHK(bus.fail_idx, e_idx, {tag, " fail_idx"})
        @(negedge clk);
        `CHK(bus.done, 1'b0, {tag, " done_width"})
        `CHK(bus.pass, e_err == 3'd0, {tag, " pass_held"})
        if (poke) begin
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) extra++;
            end
            `CHK(extra, 0, {tag, " poke_ignored"})
        end
    endtask

    initial begin
        int lat, cnt, rises;
        logic prev;
        total = 0;
        passed = 0;
        fails = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        cut = TRUTH;
        repeat (2) @(negedge clk);
        `CHK({bus.sw0, bus.sw1}, 2'b00, "reset sw")
        `CHK(bus.busy, 1'b0, "reset busy")
        `CHK(bus.done, 1'b0, "reset done")
        `CHK(bus.pass, 1'b0, "reset pass")
        `CHK(bus.err_cnt, 3'd0, "reset err_cnt")
        `CHK(bus.fail_idx, 2'd0, "reset fail_idx")
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_check(4'b1000, 1'b0, "and");
        run_check(4'b0000, 1'b0, "stuck0");
        run_check(4'b1110, 1'b0, "or");
        run_check(4'b1000, 1'b0, "and_rerun");
        run_check(4'b0111, 1'b0, "nand");
        run_check(4'b1000, 1'b1, "poke");

`ifndef GATE_BIST_START_SYNC_EN
        // level START held high: back-to-back runs, one IDLE cycle between DONE and BUSY
        @(negedge clk);
        bus.start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            cnt = 0;
            while (bus.done !== 1'b1 && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            `CHK(bus.done, 1'b1, "held done")
            @(negedge clk);
            `CHK({bus.busy, bus.done}, 2'b00, "held idle_gap")
            @(negedge clk);
            `CHK(bus.busy, 1'b1, "held rerun")
        end
        bus.start = 1'b0;
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        `CHK(bus.done, 1'b1, "held last_done")
        @(negedge clk);
`else
        // synchronised START held high for 100 cycles: exactly one run
        @(negedge clk);
        bus.start = 1'b1;
        lat = 0;
        rises = 0;
        prev = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (c == 100) bus.start = 1'b0;
            if (bus.busy === 1'b1 && prev !== 1'b1) begin
                rises++;
                if (rises == 1) lat = c;
            end
            prev = bus.busy;
        end
        `CHK(lat, 3, "sync latency")
        `CHK(rises, 1, "sync single_run")
`endif

        // asynchronous reset during SAMPLE of pattern 11, with one mismatch already counted
        cut = 4'b1110;
        launch(lat);
        `CHK(lat, LAT, "rst latency")
        repeat (2 * (DWELL + 1) + DWELL) @(negedge clk);
        `CHK({bus.sw0, bus.sw1}, 2'b11, "rst pre_pattern")
        `CHK(bus.err_cnt, 3'd1, "rst pre_err")
        #1 rst = 1'b1;
        #1 `CHK({bus.sw0, bus.sw1, bus.busy, bus.done, bus.pass, bus.err_cnt, bus.fail_idx}, 10'd0, "rst async_clear")
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) cnt++;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) cnt++;
        end
        `CHK(cnt, 0, "rst no_done")
        run_check(4'b1000, 1'b0, "post_rst");

        for (int i = 0; i < 6; i++) run_check(4'($urandom), 1'b0, "random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Built-in self-test sequencer for a 2-input combinational gate CUT (AND2-class: inputs SW0/SW1, output L).
- Drives the CUT inputs through all four patterns, holds each for a settle time, samples L, and compares it against a parameterised truth table.
- Reports busy/done/pass, the mismatch count and the first failing pattern.
- Sits between board-level START switch/LED logic and the gate under test.

Parameters:
- DWELL, 4, cycles each pattern is held before sampling; legal range >=1; DWELL=0 is an elaboration error.
- TRUTH, 4'b1000, expected L indexed by {SW0,SW1} (bit3 = pattern 11); default = AND.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  run request; level-sensitive (see optional feature).
- SW0  out  1  CUT input A, registered.
- SW1  out  1  CUT input B, registered.
- L  in  1  CUT output.
- BUSY  out  1  high while a run is in progress (DRIVE/SAMPLE).
- DONE  out  1  one-cycle pulse at end of run.
- PASS  out  1  result of last completed run; held until next run starts.
- ERR_CNT  out  3  mismatch count of current/last run, 0..4.
- FAIL_IDX  out  2  {SW0,SW1} of first mismatching pattern; 0 if none.

Behaviour:
- Reset (async, any state): state=IDLE; SW0=SW1=BUSY=DONE=PASS=0; ERR_CNT=0; FAIL_IDX=0; step=0; dwell counter=0.
- Pattern order (step 0..3): 00, 01, 11, 10 (Gray order; one input changes per step).
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE: SW0=SW1=0. If START=1 at a clock edge: go to DRIVE; step=0; ERR_CNT=0; FAIL_IDX=0; PASS=0; apply pattern 00.
- DRIVE: BUSY=1. Hold the pattern for exactly DWELL cycles; counter runs 0..DWELL-1, and at DWELL-1 go to SAMPLE.
- SAMPLE: BUSY=1; one cycle.
  - Compare L with TRUTH[{SW0,SW1}].
  - On mismatch: ERR_CNT+1; if ERR_CNT was 0, FAIL_IDX={SW0,SW1}.
  - If step<3: step+1, drive the next pattern on the same edge, go to DRIVE with counter=0.
  - If step==3: go to FINISH.
- FINISH: BUSY=0; DONE=1 for this cycle only. PASS is registered as (final ERR_CNT==0), visible from the first FINISH cycle. SW0/SW1 return to 0. Next state IDLE.
- Latency: BUSY rises the cycle after START is accepted. It stays high for exactly 4*(DWELL+1) cycles. DONE follows immediately.
- START while BUSY or in FINISH: ignored.
- START held high continuously: back-to-back runs; exactly one IDLE cycle between DONE and the next BUSY.
- ERR_CNT is 3 bits and saturates naturally at 4; no wrap is possible.
- Reset mid-run: run aborted, no DONE, all outputs at reset values.

Optional Feature:
- Macro: GATE_BIST_START_SYNC_EN.
- Defined: START passes through a 2-flop synchroniser plus rising-edge detector. Only a 0->1 transition launches a run, and held-high START gives exactly one run. Acceptance is 3 cycles after START rises. Edges arriving while busy are dropped.
- Undefined: START is used directly and is level-sensitive, as described above.

Decomposition:
- Package gate_bist_pkg holds:
  - state enum typedef (IDLE, DRIVE, SAMPLE, FINISH);
  - pattern sequence constant array {2'b00, 2'b01, 2'b11, 2'b10};
  - truth constants TRUTH_AND=4'b1000, TRUTH_OR=4'b1110, TRUTH_XOR=4'b0110, TRUTH_NAND=4'b0111.
- One sub-module: gate_bist_start_sync (synchroniser + edge detect), instantiated only under the macro.
- The CUT itself is external.

Test Plan:
1. AND2 CUT, TRUTH=4'b1000, DWELL=4, 1-cycle START -> SW0/SW1 = 00,01,11,10, each for 5 cycles; BUSY high 20 cycles; DONE 1 cycle; PASS=1, ERR_CNT=0, FAIL_IDX=0.
2. L tied 0, TRUTH=AND -> ERR_CNT=1, FAIL_IDX=2'b11, PASS=0.
3. OR-gate CUT, TRUTH=AND -> ERR_CNT=2, FAIL_IDX=2'b01, PASS=0; then AND CUT rerun -> PASS=1, ERR_CNT cleared to 0.
4. START pulsed during BUSY -> no effect, single DONE. START held high -> repeated runs with exactly one IDLE cycle between DONE and next BUSY rise.
5. RST asserted asynchronously during SAMPLE of pattern 11 -> SW0/SW1/BUSY/ERR_CNT go 0 immediately, no DONE; next START gives a normal full run.
6. GATE_BIST_START_SYNC_EN defined, START held high 100 cycles -> exactly one run; BUSY rises 3 cycles after START rises.
